// File: rtl/decode_stage.sv
// Instruction-decode stage: slices an RV64 instruction into ALU fields, owns the
// 32x64 integer register file, and presents results from one valid/ready register.
module decode_stage #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [4:0]      regA,
  output logic [11:0]     regB,
  output logic [9:0]      opcode,
  output logic [4:0]      regDest,
  output logic [19:0]     uimm,
  output logic [PC_W-1:0] o_pc,
  output logic [XLEN-1:0] regA_value,
  output logic [XLEN-1:0] regB_value,
  output logic            id_illegal
);

  logic [XLEN-1:0] rf [32];

  logic            wb_we;
  logic            accept;
  logic            hold;
  logic [4:0]      rs1_p0;
  logic [4:0]      rs2_p0;
  logic [XLEN-1:0] rs1_val_p0;
  logic [XLEN-1:0] rs2_val_p0;

  logic            vld_p1;
  logic [4:0]      rega_p1;
  logic [11:0]     regb_p1;
  logic [9:0]      opcode_p1;
  logic [4:0]      regdest_p1;
  logic [19:0]     uimm_p1;
  logic [PC_W-1:0] pc_p1;
  logic [XLEN-1:0] rega_val_p1;
  logic [XLEN-1:0] regb_val_p1;
  logic            illegal_p1;

  assign wb_we    = wb_en && (wb_dest != 5'd0);
  assign if_ready = (!vld_p1 || id_ready) && !flush;
  assign accept   = if_valid && if_ready;
  assign hold     = vld_p1 && !id_ready;
  assign rs1_p0   = if_instr[19:15];
  assign rs2_p0   = if_instr[24:20];

  // Operand read with same-edge writeback bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_val_p0 = rf[rs1_p0];
    rs2_val_p0 = rf[rs2_p0];
    if (rs1_p0 == 5'd0) rs1_val_p0 = '0;
    else if (wb_we && (wb_dest == rs1_p0)) rs1_val_p0 = wb_data;
    if (rs2_p0 == 5'd0) rs2_val_p0 = '0;
    else if (wb_we && (wb_dest == rs2_p0)) rs2_val_p0 = wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_dest] <= wb_data;
    end
  end

  // Stage boundary p0 -> p1: output register toward the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      rega_p1     <= '0;
      regb_p1     <= '0;
      opcode_p1   <= '0;
      regdest_p1  <= '0;
      uimm_p1     <= '0;
      pc_p1       <= '0;
      rega_val_p1 <= '0;
      regb_val_p1 <= '0;
      illegal_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      rega_p1     <= rs1_p0;
      regb_p1     <= if_instr[31:20];
      opcode_p1   <= {if_instr[14:12], if_instr[6:0]};
      regdest_p1  <= if_instr[11:7];
      uimm_p1     <= if_instr[31:12];
      pc_p1       <= if_pc;
      rega_val_p1 <= rs1_val_p0;
      regb_val_p1 <= rs2_val_p0;
      illegal_p1  <= (if_instr[1:0] != 2'b11);
    end else if (hold) begin
      // Stalled instruction tracks writebacks so its operands never go stale.
      if (wb_we && (wb_dest == rega_p1))      rega_val_p1 <= wb_data;
      if (wb_we && (wb_dest == regb_p1[4:0])) regb_val_p1 <= wb_data;
    end else if (vld_p1 && id_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign id_valid   = vld_p1;
  assign regA       = rega_p1;
  assign regB       = regb_p1;
  assign opcode     = opcode_p1;
  assign regDest    = regdest_p1;
  assign uimm       = uimm_p1;
  assign o_pc       = pc_p1;
  assign regA_value = rega_val_p1;
  assign regB_value = regb_val_p1;
  assign id_illegal = illegal_p1;

endmodule
